// File: rtl/rc4_key_sequencer_if.sv
// Loop handshakes, per-loop S-RAM requests, shared S-RAM port and search status
// between the RC4 key sequencer (master) and the loop engines / host (slave).
interface rc4_key_sequencer_if #(
  parameter int KEY_WIDTH = 24
);
  logic                 start;
  logic                 l1_start, l2_start, l3_start;
  logic                 l1_finish, l2_finish, l3_finish;
  logic                 l3_valid;
  logic [7:0]           l1_s_address, l2_s_address, l3_s_address;
  logic [7:0]           l1_s_data, l2_s_data, l3_s_data;
  logic                 l1_s_wren, l2_s_wren, l3_s_wren;
  logic [7:0]           s_address;
  logic [7:0]           s_data;
  logic                 s_wren;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy, found, failed;

  modport master (
    input  start, l1_finish, l2_finish, l3_finish, l3_valid,
           l1_s_address, l2_s_address, l3_s_address,
           l1_s_data, l2_s_data, l3_s_data,
           l1_s_wren, l2_s_wren, l3_s_wren,
    output l1_start, l2_start, l3_start, s_address, s_data, s_wren,
           key, busy, found, failed
  );

  modport slave (
    output start, l1_finish, l2_finish, l3_finish, l3_valid,
           l1_s_address, l2_s_address, l3_s_address,
           l1_s_data, l2_s_data, l3_s_data,
           l1_s_wren, l2_s_wren, l3_s_wren,
    input  l1_start, l2_start, l3_start, s_address, s_data, s_wren,
           key, busy, found, failed
  );
endinterface

// File: rtl/rc4_key_sequencer.sv
// RC4 search controller: runs S-init, key schedule and decrypt for each candidate
// key until a valid plaintext is reported or the key range runs out.
//   state     | meaning
//   IDLE      | waiting for start, S-RAM port parked
//   L1_GO     | one-cycle launch of S-init, loop 1 owns S-RAM
//   L1_WAIT   | waiting for l1_finish
//   L2_GO     | one-cycle launch of key schedule, loop 2 owns S-RAM
//   L2_WAIT   | waiting for l2_finish
//   L3_GO     | one-cycle launch of decrypt, loop 3 owns S-RAM
//   L3_WAIT   | waiting for l3_finish, then next key / done
//   DONE_OK   | plaintext found, key holds the winner
//   DONE_FAIL | key range exhausted
module rc4_key_sequencer #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST = KEY_WIDTH'(24'h000000),
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF)
) (
  input logic                 clk,
  input logic                 reset,
  rc4_key_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, L1_GO, L1_WAIT, L2_GO, L2_WAIT, L3_GO, L3_WAIT, DONE_OK, DONE_FAIL
  } state_t;

  state_t               state, state_nxt;
  logic [KEY_WIDTH-1:0] key_q, key_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      key_q <= KEY_FIRST;
    end else begin
      state <= state_nxt;
      key_q <= key_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    case (state)
      IDLE, DONE_OK, DONE_FAIL: begin
        if (bus.start) begin
          state_nxt = L1_GO;
          key_nxt   = KEY_FIRST;
        end
      end
      L1_GO:   state_nxt = L1_WAIT;
      L1_WAIT: if (bus.l1_finish) state_nxt = L2_GO;
      L2_GO:   state_nxt = L2_WAIT;
      L2_WAIT: if (bus.l2_finish) state_nxt = L3_GO;
      L3_GO:   state_nxt = L3_WAIT;
      L3_WAIT: begin
        if (bus.l3_finish) begin
          if (bus.l3_valid) begin
            state_nxt = DONE_OK;
          end else if (key_q != KEY_LAST) begin
            // S is rebuilt from scratch for every candidate key
            state_nxt = L1_GO;
            key_nxt   = key_q + KEY_WIDTH'(1);
          end else begin
            state_nxt = DONE_FAIL;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.l1_start = (state == L1_GO);
  assign bus.l2_start = (state == L2_GO);
  assign bus.l3_start = (state == L3_GO);
  assign bus.busy     = !(state == IDLE || state == DONE_OK || state == DONE_FAIL);
  assign bus.found    = (state == DONE_OK);
  assign bus.failed   = (state == DONE_FAIL);
  assign bus.key      = key_q;

  // only the active loop reaches the RAM; everything else sees a parked port
  always_comb begin
    bus.s_address = 8'h00;
    bus.s_data    = 8'h00;
    bus.s_wren    = 1'b0;
    case (state)
      L1_GO, L1_WAIT: begin
        bus.s_address = bus.l1_s_address;
        bus.s_data    = bus.l1_s_data;
        bus.s_wren    = bus.l1_s_wren;
      end
      L2_GO, L2_WAIT: begin
        bus.s_address = bus.l2_s_address;
        bus.s_data    = bus.l2_s_data;
        bus.s_wren    = bus.l2_s_wren;
      end
      L3_GO, L3_WAIT: begin
        bus.s_address = bus.l3_s_address;
        bus.s_data    = bus.l3_s_data;
        bus.s_wren    = bus.l3_s_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_sequencer.sv
// Bench for rc4_key_sequencer: two instances (default range and KEY_LAST=2) driven by
// behavioural loop engines and checked every cycle against an event-level model.
module tb_rc4_key_sequencer;
  localparam int KW = 24;

  typedef struct packed {
    logic          l1, l2, l3, busy, found, failed, wren;
    logic [7:0]    addr, data;
    logic [KW-1:0] key;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic          start_drv [2] = '{1'b0, 1'b0};
  int            vmode     [2] = '{0, 0};
  logic [KW-1:0] vtarget   [2] = '{24'h0, 24'h0};
  int            lat1      [2] = '{4, 4};
  int            lat2      [2] = '{4, 4};
  int            lat3      [2] = '{4, 4};
  logic          junk_en   [2] = '{1'b0, 1'b0};
  logic          ovr_en    [2] = '{1'b0, 1'b0};
  logic [2:0]    stray_fin [2] = '{3'b000, 3'b000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam logic [KW-1:0] LAST = (g == 0) ? 24'h3FFFFF : 24'h000002;

    rc4_key_sequencer_if #(.KEY_WIDTH(KW)) bus ();

    rc4_key_sequencer #(
      .KEY_WIDTH(KW),
      .KEY_FIRST(24'h000000),
      .KEY_LAST (LAST)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    outs_t act_o;
    assign act_o = {bus.l1_start, bus.l2_start, bus.l3_start, bus.busy, bus.found,
                    bus.failed, bus.s_wren, bus.s_address, bus.s_data, bus.key};
    assign bus.start = start_drv[g];

    // behavioural loop engines: finish N cycles after their launch, plus optional noise
    int c1 = 0, c2 = 0, c3 = 0;
    always @(negedge clk) begin
      logic [2:0] fin;
      logic       v;
      fin = 3'b000;
      if (reset) begin
        c1 = 0; c2 = 0; c3 = 0;
      end else begin
        if (c1 > 0) begin c1--; if (c1 == 0) fin[0] = 1'b1; end
        if (c2 > 0) begin c2--; if (c2 == 0) fin[1] = 1'b1; end
        if (c3 > 0) begin c3--; if (c3 == 0) fin[2] = 1'b1; end
        if (bus.l1_start === 1'b1) c1 = lat1[g];
        if (bus.l2_start === 1'b1) c2 = lat2[g];
        if (bus.l3_start === 1'b1) c3 = lat3[g];
      end
      fin = fin | stray_fin[g];
      if (junk_en[g] && $urandom_range(0, 19) == 0) fin[$urandom_range(0, 2)] = 1'b1;
      case (vmode[g])
        0:       v = 1'b1;
        1:       v = (bus.key === vtarget[g]);
        2:       v = 1'b0;
        default: v = ($urandom_range(0, 5) == 0);
      endcase
      bus.l1_finish = fin[0];
      bus.l2_finish = fin[1];
      bus.l3_finish = fin[2];
      bus.l3_valid  = fin[2] ? v : (junk_en[g] ? 1'($urandom_range(0, 1)) : 1'b0);
      if (ovr_en[g]) begin
        bus.l1_s_address = 8'h33; bus.l1_s_data = 8'h44; bus.l1_s_wren = 1'b1;
        bus.l2_s_address = 8'h5A; bus.l2_s_data = 8'h11; bus.l2_s_wren = 1'b1;
        bus.l3_s_address = 8'h77; bus.l3_s_data = 8'h66; bus.l3_s_wren = 1'b1;
      end else if (junk_en[g]) begin
        bus.l1_s_address = 8'($urandom); bus.l1_s_data = 8'($urandom); bus.l1_s_wren = 1'($urandom);
        bus.l2_s_address = 8'($urandom); bus.l2_s_data = 8'($urandom); bus.l2_s_wren = 1'($urandom);
        bus.l3_s_address = 8'($urandom); bus.l3_s_data = 8'($urandom); bus.l3_s_wren = 1'($urandom);
      end else begin
        bus.l1_s_address = 8'h00; bus.l1_s_data = 8'h00; bus.l1_s_wren = 1'b0;
        bus.l2_s_address = 8'h00; bus.l2_s_data = 8'h00; bus.l2_s_wren = 1'b0;
        bus.l3_s_address = 8'h00; bus.l3_s_data = 8'h00; bus.l3_s_wren = 1'b0;
      end
    end

    // reference: which loop is active (0 = none), whether its launch is this cycle
    int            m_phase  = 0;
    bit            m_launch = 1'b0;
    logic [KW-1:0] m_key    = '0;
    bit            m_found  = 1'b0;
    bit            m_failed = 1'b0;
    always @(posedge clk or posedge reset) begin
      logic [3:1] f;
      f = {bus.l3_finish, bus.l2_finish, bus.l1_finish};
      if (reset) begin
        m_phase = 0; m_launch = 1'b0; m_key = '0; m_found = 1'b0; m_failed = 1'b0;
      end else if (m_phase == 0) begin
        if (bus.start === 1'b1) begin
          m_key = '0; m_found = 1'b0; m_failed = 1'b0; m_phase = 1; m_launch = 1'b1;
        end
      end else if (m_launch) begin
        m_launch = 1'b0;
      end else if (f[m_phase] === 1'b1) begin
        if (m_phase < 3) begin
          m_phase = m_phase + 1; m_launch = 1'b1;
        end else if (bus.l3_valid === 1'b1) begin
          m_phase = 0; m_found = 1'b1;
        end else if (m_key != LAST) begin
          m_key = m_key + 1'b1; m_phase = 1; m_launch = 1'b1;
        end else begin
          m_phase = 0; m_failed = 1'b1;
        end
      end
    end

    int            l1_cyc[$], l2_cyc[$], l3_cyc[$];
    logic [KW-1:0] l1_key[$];
    always @(negedge clk) begin
      if (bus.l1_start === 1'b1) begin l1_cyc.push_back(cyc); l1_key.push_back(bus.key); end
      if (bus.l2_start === 1'b1) l2_cyc.push_back(cyc);
      if (bus.l3_start === 1'b1) l3_cyc.push_back(cyc);
    end

    always @(negedge clk) begin
      outs_t e;
      #2;
      e = '0;
      e.l1     = m_launch && m_phase == 1;
      e.l2     = m_launch && m_phase == 2;
      e.l3     = m_launch && m_phase == 3;
      e.busy   = (m_phase != 0);
      e.found  = m_found;
      e.failed = m_failed;
      e.key    = m_key;
      case (m_phase)
        1: begin e.wren = bus.l1_s_wren; e.addr = bus.l1_s_address; e.data = bus.l1_s_data; end
        2: begin e.wren = bus.l2_s_wren; e.addr = bus.l2_s_address; e.data = bus.l2_s_data; end
        3: begin e.wren = bus.l3_s_wren; e.addr = bus.l3_s_address; e.data = bus.l3_s_data; end
        default: ;
      endcase
      check($sformatf("cycle%0d_inst%0d", cyc, g), 64'(act_o), 64'(e));
    end
  end

  function automatic outs_t get_out(input int g);
    return (g == 0) ? g_inst[0].act_o : g_inst[1].act_o;
  endfunction

  function automatic int model_phase(input int g);
    return (g == 0) ? g_inst[0].m_phase : g_inst[1].m_phase;
  endfunction

  function automatic int log_size(input int g, input int n);
    if (g == 0) return (n == 1) ? g_inst[0].l1_cyc.size() : (n == 2) ? g_inst[0].l2_cyc.size() : g_inst[0].l3_cyc.size();
    return (n == 1) ? g_inst[1].l1_cyc.size() : (n == 2) ? g_inst[1].l2_cyc.size() : g_inst[1].l3_cyc.size();
  endfunction

  task automatic pulse_start(input int g, output int c);
    @(negedge clk);
    start_drv[g] = 1'b1;
    c = cyc;
    @(negedge clk);
    start_drv[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int maxc, input string nm);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (model_phase(g) == 0) break;
      @(negedge clk);
    end
    check({nm, "_timeout"}, 64'(i >= maxc), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t o;
    int    cs, b1, b2, b3, i;

    repeat (3) @(negedge clk);
    #3;
    check("reset_state_inst0", 64'(get_out(0)), 64'(0));
    check("reset_state_inst1", 64'(get_out(1)), 64'(0));
    reset = 1'b0;

    // full pass, first key valid, long loop latencies
    lat1[0] = 256; lat2[0] = 768; lat3[0] = 32; vmode[0] = 0;
    b1 = log_size(0, 1); b2 = log_size(0, 2); b3 = log_size(0, 3);
    pulse_start(0, cs);
    wait_done(0, 3000, "s1");
    o = get_out(0);
    check("s1_l1_pulses", 64'(log_size(0, 1) - b1), 64'(1));
    check("s1_l2_pulses", 64'(log_size(0, 2) - b2), 64'(1));
    check("s1_l3_pulses", 64'(log_size(0, 3) - b3), 64'(1));
    check("s1_start_to_l1", 64'(g_inst[0].l1_cyc[b1] - cs), 64'(1));
    check("s1_l1_to_l2", 64'(g_inst[0].l2_cyc[b2] - g_inst[0].l1_cyc[b1]), 64'(257));
    check("s1_l2_to_l3", 64'(g_inst[0].l3_cyc[b3] - g_inst[0].l2_cyc[b2]), 64'(769));
    check("s1_l3_to_done", 64'(cyc - g_inst[0].l3_cyc[b3]), 64'(33));
    check("s1_flags", 64'({o.found, o.busy, o.failed}), 64'(3'b100));
    check("s1_key", 64'(o.key), 64'(0));

    // valid only at key 3, restart from DONE_OK
    lat1[0] = 5; lat2[0] = 7; lat3[0] = 3; vmode[0] = 1; vtarget[0] = 24'h000003;
    b1 = log_size(0, 1);
    pulse_start(0, cs);
    o = get_out(0);
    check("s2_flags_cleared", 64'({o.found, o.failed, o.busy}), 64'(3'b001));
    wait_done(0, 500, "s2");
    o = get_out(0);
    check("s2_l1_pulses", 64'(log_size(0, 1) - b1), 64'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("s2_key_iter%0d", k), 64'(g_inst[0].l1_key[b1 + k]), 64'(k));
    check("s2_flags", 64'({o.found, o.failed}), 64'(2'b10));
    check("s2_key", 64'(o.key), 64'(3));

    // short range exhausted
    lat1[1] = 4; lat2[1] = 6; lat3[1] = 2; vmode[1] = 2;
    b1 = log_size(1, 1);
    pulse_start(1, cs);
    wait_done(1, 500, "s3");
    o = get_out(1);
    check("s3_l1_pulses", 64'(log_size(1, 1) - b1), 64'(3));
    check("s3_flags", 64'({o.failed, o.found, o.busy}), 64'(3'b100));
    check("s3_key", 64'(o.key), 64'(2));
    repeat (20) @(negedge clk);
    check("s3_no_fourth_iter", 64'(log_size(1, 1) - b1), 64'(3));

    // arbitration while loop 2 owns the port
    lat1[0] = 8; lat2[0] = 60; lat3[0] = 50; vmode[0] = 2;
    pulse_start(0, cs);
    for (i = 0; i < 200; i++) begin
      if (g_inst[0].m_phase == 2 && !g_inst[0].m_launch) break;
      @(negedge clk);
    end
    check("s4_reach_l2_wait", 64'(i >= 200), 64'(0));
    ovr_en[0] = 1'b1; stray_fin[0] = 3'b001;
    @(negedge clk); #3;
    o = get_out(0);
    check("s4_mux_addr", 64'(o.addr), 64'(8'h5A));
    check("s4_mux_data", 64'(o.data), 64'(8'h11));
    check("s4_mux_wren", 64'(o.wren), 64'(1));
    ovr_en[0] = 1'b0; stray_fin[0] = 3'b000;
    @(negedge clk); #3;
    o = get_out(0);
    check("s4_state_held", 64'({o.l1, o.l2, o.l3, o.busy}), 64'(4'b0001));

    // reset during L3_WAIT of the second key, then restart
    for (i = 0; i < 600; i++) begin
      if (g_inst[0].m_phase == 3 && !g_inst[0].m_launch && g_inst[0].m_key == 1) break;
      @(negedge clk);
    end
    check("s5_reach_l3_key1", 64'(i >= 600), 64'(0));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("s5_async_reset", 64'(get_out(0)), 64'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    vmode[0] = 0; lat1[0] = 3; lat2[0] = 3; lat3[0] = 3;
    b1 = log_size(0, 1);
    pulse_start(0, cs);
    wait_done(0, 200, "s5");
    o = get_out(0);
    check("s5_restart_key", 64'(g_inst[0].l1_key[b1]), 64'(0));
    check("s5_done", 64'({o.found, o.failed, o.busy}), 64'(3'b100));

    // random traffic, noise on every loop, random starts and resets
    junk_en[0] = 1'b1; junk_en[1] = 1'b1; vmode[0] = 3; vmode[1] = 2;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        start_drv[g] = ($urandom_range(0, 7) == 0);
        lat1[g] = $urandom_range(1, 6);
        lat2[g] = $urandom_range(1, 6);
        lat3[g] = $urandom_range(1, 6);
      end
      if (n == 1500 || n == 3100) begin
        #4 reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
      end
    end
    junk_en[0] = 1'b0; junk_en[1] = 1'b0;
    start_drv[0] = 1'b0; start_drv[1] = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_key_sequencer.md
Name: rc4_key_sequencer

Overview:
Top-level controller for the RC4 decryption datapath. It sequences the three loop engines: S-init (loop 1), key-schedule shuffle (loop 2) and decrypt (loop 3, the unit that reads S, the encrypted ROM and writes the decrypted RAM). It is also the single owner of the shared S-RAM port and muxes it to whichever loop is active. It iterates candidate keys until loop 3 reports a valid plaintext or the key range is exhausted.

Parameters:
KEY_WIDTH, 24, width of the secret key driven to loop 2
KEY_FIRST, 24'h000000, first candidate key tried after start
KEY_LAST, 24'h3FFFFF, last candidate key; search stops after this one

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled only in IDLE, begins a search
l1_start / l2_start / l3_start  out  1 each  one-cycle launch pulse to loop 1 / 2 / 3
l1_finish / l2_finish / l3_finish  in  1 each  one-cycle done pulse from loop 1 / 2 / 3
l3_valid  in  1  plaintext-valid flag from loop 3, qualified by l3_finish
l1_s_address / l2_s_address / l3_s_address  in  8 each  S-RAM address from loop 1 / 2 / 3
l1_s_data / l2_s_data / l3_s_data  in  8 each  S-RAM write data from loop 1 / 2 / 3
l1_s_wren / l2_s_wren / l3_s_wren  in  1 each  S-RAM write enable from loop 1 / 2 / 3
s_address  out  8  S-RAM address
s_data  out  8  S-RAM write data
s_wren  out  1  S-RAM write enable
key  out  KEY_WIDTH  current candidate key, stable for a whole iteration
busy  out  1  high from leaving IDLE until DONE_OK/DONE_FAIL
found  out  1  sticky: last search succeeded
failed  out  1  sticky: last search exhausted the key range

Behaviour:
- Reset (async, immediate): state IDLE; all lN_start=0; s_wren=0, s_address=0, s_data=0; key=KEY_FIRST; busy=found=failed=0.
- States: IDLE, L1_GO, L1_WAIT, L2_GO, L2_WAIT, L3_GO, L3_WAIT, DONE_OK, DONE_FAIL. All outputs are Moore, decoded from registered state.
- IDLE: start=1 at edge -> key<=KEY_FIRST, found<=0, failed<=0, go to L1_GO.
- LN_GO: lN_start=1 for exactly one cycle, then LN_WAIT unconditionally. lN_finish during LN_GO is ignored.
- L1_WAIT: l1_finish -> L2_GO. L2_WAIT: l2_finish -> L3_GO.
- L3_WAIT, on l3_finish:
  - l3_valid=1 -> DONE_OK.
  - l3_valid=0 and key!=KEY_LAST -> key<=key+1, go to L1_GO (S is re-initialised for every key).
  - l3_valid=0 and key==KEY_LAST -> DONE_FAIL. Key never wraps.
- DONE_OK: found=1, busy=0. DONE_FAIL: failed=1, busy=0. Key holds its last value. start=1 restarts exactly as from IDLE; flags clear on restart.
- Latency: start edge to l1_start high = 1 cycle. lN_finish edge to next l(N+1)_start = 1 cycle. Failed l3_finish to next l1_start = 1 cycle.
- S-RAM arbitration (combinational mux on state):
  - L1_GO/L1_WAIT: loop 1 owns the port.
  - L2_*: loop 2 owns the port.
  - L3_*: loop 3 owns the port.
  - IDLE/DONE_*: port parked (address 0, data 0, wren 0).
  - Non-owner wren, address and finish are ignored, so a non-owner write can never reach the RAM.
- start while busy: ignored. Simultaneous finish pulses: only the active loop's pulse is honoured.
- Reset mid-operation: all launches stop and s_wren drops immediately. The search restarts only on a new start.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 within the same cycle, key=0x000000, state IDLE.
- start=1, behavioural loops finish 256/768/32 cycles after their launch, l3_valid=1 -> one pulse each on l1/l2/l3_start, each 1 cycle after the prior finish; found=1, busy=0, key=0x000000.
- l3_valid=1 only when key==3 -> exactly 4 l1_start pulses, keys 0..3 observed, found=1, key=3.
- KEY_LAST=2 override, l3_valid always 0 -> 3 iterations, failed=1, found=0, key=2, no 4th l1_start.
- During L2_WAIT drive l2 address=0x5A, data=0x11, wren=1, plus l1 wren=1 and a stray l1_finish pulse -> s_address=0x5A, s_data=0x11, s_wren=1, state unchanged.
- Reset in L3_WAIT, then start -> search restarts at KEY_FIRST, found/failed=0.
